branch_seq: RTL and testbench
=============================

# branch_seq

Instruction-timing sequencer for the MOSby core. It fetches an opcode from the data bus, steps the 6502-style T-state machine, and drives the existing branch unit's control inputs and the PC's increment/low-byte strobes, so that branch and jump instructions execute with 6502-exact cycle counts. It sits between the data bus and the branch unit, clocked by the same phase clock as the PC.

## Interface
- No parameters.
- clk  in  1  phase clock, the same domain as the PC; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  memory ready; low stalls the sequencer.
- data_in  in  8  data bus, holding the opcode or operand byte for the current cycle.
- branch_taken  in  1  condition result from the branch unit for the current branch_op and status.
- page_cross  in  1  carry or borrow out of the PC low-byte offset add.
- sync  out  1  high during an opcode-fetch cycle.
- pc_inc  out  1  PC increment strobe (drives pc_inc_decoder).
- lower_byte  out  1  PC low-byte offset-add strobe (drives lower_byte_decoder).
- branch_con  out  1  conditional-branch strobe.
- branch_uncon  out  1  unconditional PC load strobe.
- branch_op  out  3  condition select, equal to ir[7:5].
- ir  out  8  latched opcode.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Opcode classes:
  - BR: any opcode matching xxx10000 (10,30,50,70,90,B0,D0,F0).
  - JMP: 4C.
  - NOP: EA.
  - Anything else is ILL, which executes as NOP and pulses illegal in DEC.
- States:
  - RESET: entered while rst is low; goes to FETCH on the first enabled cycle after release.
  - FETCH: sync=1, pc_inc=1; ir<=data_in at the edge; next state DEC.
  - DEC for BR: pc_inc=1 (fetch offset) and branch_con=1. If branch_taken, next state BR_ADD; otherwise FETCH.
  - DEC for JMP: pc_inc=1 (fetch low byte); next state JMP_HI.
  - DEC for NOP/ILL: no strobes; next state FETCH.
  - BR_ADD: lower_byte=1. If page_cross, next state BR_FIX; otherwise FETCH.
  - BR_FIX: branch_uncon=1 (high-byte fix-up load); next state FETCH.
  - JMP_HI: branch_uncon=1 (load {data_in, low}); next state FETCH.
- Cycle counts are fixed:
  - NOP, ILL and not-taken BR: 2 cycles.
  - Taken BR, same page: 3 cycles.
  - Taken BR, page cross: 4 cycles.
  - JMP: 3 cycles.
- branch_op always equals ir[7:5], including for non-branch opcodes. It is don't-care for the branch unit when branch_con is 0.
- rdy low:
  - The state register and ir hold.
  - sync, pc_inc, lower_byte, branch_con, branch_uncon and illegal are forced to 0.
  - The cycle repeats when rdy returns high.

## Timing
- Reset values: state RESET; ir=EA; branch_op=3'b111; all strobes, sync and illegal are 0.
- Strobes and sync are combinational decodes of the registered state, ir and rdy. They are valid after the clock edge and sampled by the PC on the next edge.
- ir is loaded at the end of FETCH, so it is valid throughout DEC onward.
- branch_taken is sampled only at the DEC→next edge. page_cross is sampled only at the BR_ADD→next edge.
- When rst is asserted mid-instruction, the block goes immediately (asynchronously) to RESET with reset values. No partial instruction completes.
- Back-to-back instructions: FETCH follows the final cycle directly, with no idle cycle.
- rdy falling during BR_ADD: page_cross is re-sampled on the cycle in which rdy is high.

## Structure
- Shared package mosby_pkg holds:
  - The state enum: RESET, FETCH, DEC, BR_ADD, BR_FIX, JMP_HI.
  - OP_JMP_ABS=8'h4C, OP_NOP=8'hEA.
  - BR_MASK=8'h1F and BR_MATCH=8'h10.
  - The class enum: BR, JMP, NOP, ILL.
- One sub-module, op_class: a purely combinational opcode→class decoder, shared with later decode logic. The FSM and output decode live in branch_seq.

## Test plan
- Reset held low for 3 cycles, then released with data_in=EA → ir=EA, sync high on the first FETCH, then NOP takes 2 cycles with pc_inc asserted only in FETCH.
- Opcode D0 (BNE) with branch_taken=0 → branch_op=3'b110, branch_con=1 in DEC, FETCH in cycle 3, lower_byte never asserted.
- Opcode F0 with branch_taken=1 and page_cross=0 → lower_byte in cycle 3, sync in cycle 4. The same with page_cross=1 → branch_uncon in cycle 4, sync in cycle 5.
- Opcode 4C with operands 34, 12 → pc_inc in cycles 1–2, branch_uncon in cycle 3 with data_in=12, sync in cycle 4.
- Opcode 02 → illegal pulses exactly one cycle in DEC; next sync arrives 2 cycles after the opcode's sync.
- rdy held low for 2 cycles in BR_ADD → all strobes 0 and state held; lower_byte asserts once after rdy rises. rst asserted mid-JMP_HI → outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mosby_pkg.sv
// Shared definitions for the MOSby core: sequencer states, opcode classes
// and the opcode constants the sequencer recognises.
package mosby_pkg;

  // T-state of the instruction sequencer
  typedef enum logic [2:0] {
    RESET  = 3'd0,
    FETCH  = 3'd1,
    DEC    = 3'd2,
    BR_ADD = 3'd3,
    BR_FIX = 3'd4,
    JMP_HI = 3'd5
  } state_t;

  // Coarse opcode class used to pick the T-state path
  typedef enum logic [1:0] {
    BR  = 2'd0,
    JMP = 2'd1,
    NOP = 2'd2,
    ILL = 2'd3
  } op_class_t;

  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] BR_MASK    = 8'h1F;
  localparam logic [7:0] BR_MATCH   = 8'h10;

  // Relative branches all share the xxx10000 pattern; the top bits pick the condition
  function automatic logic is_branch(input logic [7:0] opcode);
    return (opcode & BR_MASK) == BR_MATCH;
  endfunction

endpackage

// File: rtl/op_class.sv
// Combinational opcode classifier; also intended for reuse by later decode logic.
module op_class
  import mosby_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] cls
);

  op_class_t cls_s;

  // Map the opcode onto its execution class; unknown opcodes fall to ILL
  always_comb begin
    cls_s = ILL;
    if (is_branch(opcode)) begin
      cls_s = BR;
    end else if (opcode == OP_JMP_ABS) begin
      cls_s = JMP;
    end else if (opcode == OP_NOP) begin
      cls_s = NOP;
    end else begin
      cls_s = ILL;
    end
  end

  assign cls = cls_s;

endmodule

// File: rtl/branch_seq.sv
// Instruction-timing sequencer: fetches the opcode, walks the T-states and
// produces the PC / branch-unit strobes with 6502-exact cycle counts.
// Strobes are decoded from the registered state so the PC samples them on
// the following edge; rdy low freezes the state and silences every strobe.
module branch_seq
  import mosby_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] data_in,
  input  logic       branch_taken,
  input  logic       page_cross,
  output logic       sync,
  output logic       pc_inc,
  output logic       lower_byte,
  output logic       branch_con,
  output logic       branch_uncon,
  output logic [2:0] branch_op,
  output logic [7:0] ir,
  output logic       illegal
);

  state_t     state_r;
  logic [7:0] ir_r;
  logic [1:0] cls_raw_s;
  op_class_t  cls_s;

  logic sync_s;
  logic pc_inc_s;
  logic lower_byte_s;
  logic branch_con_s;
  logic branch_uncon_s;
  logic illegal_s;

  op_class u_op_class (
    .opcode (ir_r),
    .cls    (cls_raw_s)
  );

  assign cls_s = op_class_t'(cls_raw_s);

  // T-state sequencing and opcode latch; everything holds while rdy is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RESET;
      ir_r    <= OP_NOP;
    end else if (rdy) begin
      case (state_r)
        RESET: begin
          state_r <= FETCH;
        end
        FETCH: begin
          ir_r    <= data_in;
          state_r <= DEC;
        end
        DEC: begin
          case (cls_s)
            BR: begin
              if (branch_taken) begin
                state_r <= BR_ADD;
              end else begin
                state_r <= FETCH;
              end
            end
            JMP: begin
              state_r <= JMP_HI;
            end
            default: begin
              state_r <= FETCH;
            end
          endcase
        end
        BR_ADD: begin
          if (page_cross) begin
            state_r <= BR_FIX;
          end else begin
            state_r <= FETCH;
          end
        end
        BR_FIX: begin
          state_r <= FETCH;
        end
        JMP_HI: begin
          state_r <= FETCH;
        end
        default: begin
          state_r <= RESET;
        end
      endcase
    end
  end

  // Strobe decode from the current state and opcode class, gated by rdy
  always_comb begin
    sync_s         = 1'b0;
    pc_inc_s       = 1'b0;
    lower_byte_s   = 1'b0;
    branch_con_s   = 1'b0;
    branch_uncon_s = 1'b0;
    illegal_s      = 1'b0;
    if (rdy) begin
      case (state_r)
        FETCH: begin
          sync_s   = 1'b1;
          pc_inc_s = 1'b1;
        end
        DEC: begin
          case (cls_s)
            BR: begin
              pc_inc_s     = 1'b1;
              branch_con_s = 1'b1;
            end
            JMP: begin
              pc_inc_s = 1'b1;
            end
            ILL: begin
              illegal_s = 1'b1;
            end
            default: begin
              pc_inc_s = 1'b0;
            end
          endcase
        end
        BR_ADD: begin
          lower_byte_s = 1'b1;
        end
        BR_FIX: begin
          branch_uncon_s = 1'b1;
        end
        JMP_HI: begin
          branch_uncon_s = 1'b1;
        end
        default: begin
          sync_s = 1'b0;
        end
      endcase
    end else begin
      sync_s         = 1'b0;
      pc_inc_s       = 1'b0;
      lower_byte_s   = 1'b0;
      branch_con_s   = 1'b0;
      branch_uncon_s = 1'b0;
      illegal_s      = 1'b0;
    end
  end

  assign sync         = sync_s;
  assign pc_inc       = pc_inc_s;
  assign lower_byte   = lower_byte_s;
  assign branch_con   = branch_con_s;
  assign branch_uncon = branch_uncon_s;
  assign illegal      = illegal_s;
  assign ir           = ir_r;
  assign branch_op    = ir_r[7:5];

endmodule

// File: tb/tb_branch_seq.sv
// Bench for branch_seq. The reference model expands every instruction into
// its list of per-cycle strobe patterns when it is fetched; a cycle with rdy
// low expects silence and consumes nothing from the list.
module tb_branch_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [7:0] data_in;
  logic       branch_taken;
  logic       page_cross;
  logic       sync, pc_inc, lower_byte, branch_con, branch_uncon, illegal;
  logic [2:0] branch_op;
  logic [7:0] ir;

  branch_seq dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .data_in      (data_in),
    .branch_taken (branch_taken),
    .page_cross   (page_cross),
    .sync         (sync),
    .pc_inc       (pc_inc),
    .lower_byte   (lower_byte),
    .branch_con   (branch_con),
    .branch_uncon (branch_uncon),
    .branch_op    (branch_op),
    .ir           (ir),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  // one expected cycle: strobes plus which condition input is sampled there
  typedef struct packed {
    logic sy, pi, lb, bc, bu, il;
    logic need_bt, need_pc;
  } cyc_t;

  cyc_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         lb_seen  = 0;
  int         ill_seen = 0;
  logic       chk_en   = 1'b0;
  logic [5:0] exp_out  = 6'd0;
  logic [7:0] exp_ir   = 8'hEA;
  logic [7:0] model_ir = 8'hEA;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every cycle the outputs are meaningful, compare them with the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("strobes", {26'd0, sync, pc_inc, lower_byte, branch_con, branch_uncon, illegal},
            {26'd0, exp_out});
      check("ir", {24'd0, ir}, {24'd0, exp_ir});
      check("branch_op", {29'd0, branch_op}, {29'd0, exp_ir[7:5]});
      if (lower_byte) lb_seen++;
      if (illegal) ill_seen++;
    end
  end

  // Append the cycle list of one instruction; n returns its cycle count
  task automatic build(input logic [7:0] op, input logic bt, input logic pcx, output int n);
    cyc_t e;
    e = '0; e.sy = 1'b1; e.pi = 1'b1; q.push_back(e); n = 1;
    e = '0;
    if ((op & 8'h1F) == 8'h10) begin
      e.pi = 1'b1; e.bc = 1'b1; e.need_bt = 1'b1; q.push_back(e); n++;
      if (bt) begin
        e = '0; e.lb = 1'b1; e.need_pc = 1'b1; q.push_back(e); n++;
        if (pcx) begin
          e = '0; e.bu = 1'b1; q.push_back(e); n++;
        end
      end
    end else if (op == 8'h4C) begin
      e.pi = 1'b1; q.push_back(e);
      e = '0; e.bu = 1'b1; q.push_back(e);
      n += 2;
    end else if (op == 8'hEA) begin
      q.push_back(e); n++;
    end else begin
      e.il = 1'b1; q.push_back(e); n++;
    end
  endtask

  task automatic summary_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Run one instruction to completion (called just after a rising edge).
  // lowpct: chance of rdy low per cycle; hold: forced rdy-low cycles in BR_ADD;
  // abort: assert reset in the middle of JMP_HI; explen: literal length or -1.
  task automatic run(input logic [7:0] op, input logic bt, input logic pcx,
                     input int lowpct, input int hold, input logic abort, input int explen);
    int   n;
    int   h;
    cyc_t f;
    logic r;
    h = hold;
    build(op, bt, pcx, n);
    if (explen >= 0) check("model_len", n, explen);
    while (q.size() > 0) begin
      f = q[0];
      r = ($urandom_range(0, 99) >= lowpct);
      if (f.lb && h > 0) begin
        r = 1'b0;
        h--;
      end
      rdy = r;
      if (f.sy) data_in = op;
      else if (op == 8'h4C && f.pi) data_in = 8'h34;
      else if (op == 8'h4C && f.bu) data_in = 8'h12;
      else data_in = 8'($urandom_range(0, 255));
      branch_taken = (f.need_bt && r) ? bt  : 1'($urandom_range(0, 1));
      page_cross   = (f.need_pc && r) ? pcx : 1'($urandom_range(0, 1));
      exp_out = r ? {f.sy, f.pi, f.lb, f.bc, f.bu, f.il} : 6'd0;
      exp_ir  = model_ir;
      if (abort && f.bu && r) begin
        chk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_strobes",
              {26'd0, sync, pc_inc, lower_byte, branch_con, branch_uncon, illegal}, 32'd0);
        check("async_rst_ir", {24'd0, ir}, 32'h0000_00EA);
        check("async_rst_bop", {29'd0, branch_op}, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        f = '0;
        q.push_back(f);
        model_ir = 8'hEA;
        chk_en = 1'b1;
        return;
      end
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 50000) begin
        failures++;
        $display("FAIL timeout cycles=%0d required<=50000", cyc);
        summary_and_finish();
      end
      if (r) begin
        if (f.sy) model_ir = op;
        void'(q.pop_front());
      end
    end
  endtask

  initial begin
    cyc_t e;
    logic [7:0] op;
    rst = 1'b0; rdy = 1'b1; data_in = 8'hEA; branch_taken = 1'b0; page_cross = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes",
          {26'd0, sync, pc_inc, lower_byte, branch_con, branch_uncon, illegal}, 32'd0);
    check("reset_ir", {24'd0, ir}, 32'h0000_00EA);
    check("reset_bop", {29'd0, branch_op}, 32'd7);
    rst = 1'b1;
    e = '0;
    q.push_back(e);

    // directed cases from the block's cycle-count rules
    run(8'hEA, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    lb_seen = 0;
    run(8'hD0, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    check("d0_bop", {29'd0, branch_op}, 32'd6);
    check("d0_no_lb", lb_seen, 0);
    run(8'hF0, 1'b1, 1'b0, 0, 0, 1'b0, 3);
    run(8'hF0, 1'b1, 1'b1, 0, 0, 1'b0, 4);
    run(8'h4C, 1'b0, 1'b0, 0, 0, 1'b0, 3);
    check("jmp_ir", {24'd0, ir}, 32'h0000_004C);
    ill_seen = 0;
    run(8'h02, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    check("ill_pulse_count", ill_seen, 1);
    lb_seen = 0;
    run(8'hF0, 1'b1, 1'b1, 0, 2, 1'b0, 4);
    check("hold_lb_once", lb_seen, 1);
    run(8'h4C, 1'b0, 1'b0, 0, 0, 1'b1, 3);
    run(8'h10, 1'b1, 1'b0, 0, 0, 1'b0, 3);

    // randomized instruction stream with random rdy stalls
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: op = {3'($urandom_range(0, 7)), 5'h10};
        1: op = 8'h4C;
        2: op = 8'hEA;
        default: op = 8'($urandom_range(0, 255));
      endcase
      run(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 25, 0,
          ($urandom_range(0, 19) == 0), -1);
    end

    chk_en = 1'b0;
    summary_and_finish();
  end

endmodule
